// File: rtl/delay_line_param_if.sv
// Bundle of the delay line's control inputs and registered result outputs.
// sample_en is a one-sided strobe with no ready: every cycle it is high
// (and neither rst nor flush is high) the delay line accepts sample_in.
// The slave always accepts, so there is no backpressure to honour.
interface delay_line_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int SEL_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = DATA_W + $clog2(DEPTH);

  logic                      sample_en;
  logic                      flush;
  logic [DATA_W-1:0]         sample_in;
  logic [SEL_W-1:0]          tap_sel;
  logic [DATA_W*DEPTH-1:0]   taps;
  logic [DATA_W-1:0]         tap_out;
  logic [CNT_W-1:0]          fill;
  logic                      full;
  logic [SUM_W-1:0]          win_sum;

  modport master (
    output sample_en, flush, sample_in, tap_sel,
    input  taps, tap_out, fill, full, win_sum
  );

  modport slave (
    input  sample_en, flush, sample_in, tap_sel,
    output taps, tap_out, fill, full, win_sum
  );
endinterface

// File: rtl/delay_line_param.sv
// Parameterised sample delay line: DEPTH taps shifted on qualified strobes,
// with synchronous flush, saturating fill count, registered tap read port
// and an incrementally maintained window sum. All outputs are registered.
module delay_line_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  delay_line_param_if.slave  bus
);
  localparam int SEL_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = DATA_W + $clog2(DEPTH);

  logic [DATA_W-1:0] taps_q [DEPTH];
  logic [DATA_W-1:0] taps_d [DEPTH];
  logic [DATA_W-1:0] tap_out_q, tap_out_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              full_q, full_d;
  logic [SUM_W-1:0]  win_sum_q, win_sum_d;

  // Tap/fill/sum next state: flush beats sample_en, otherwise hold.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) taps_d[k] = taps_q[k];
    fill_d    = fill_q;
    full_d    = full_q;
    win_sum_d = win_sum_q;
    if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) taps_d[k] = '0;
      fill_d    = '0;
      full_d    = 1'b0;
      win_sum_d = '0;
    end else if (bus.sample_en) begin
      taps_d[0] = bus.sample_in;
      for (int k = 1; k < DEPTH; k++) taps_d[k] = taps_q[k-1];
      // Unfilled taps hold 0, so subtracting the outgoing tap is always exact.
      win_sum_d = win_sum_q + SUM_W'(bus.sample_in) - SUM_W'(taps_q[DEPTH-1]);
      if (fill_q != CNT_W'(DEPTH)) fill_d = fill_q + CNT_W'(1);
      full_d = (fill_d == CNT_W'(DEPTH));
    end
  end

  // Read port: select from pre-shift taps; out-of-range index reads 0.
  always_comb begin
    tap_out_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.tap_sel == SEL_W'(k)) tap_out_d = taps_q[k];
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) taps_q[k] <= '0;
      tap_out_q <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      win_sum_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) taps_q[k] <= taps_d[k];
      tap_out_q <= tap_out_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      win_sum_q <= win_sum_d;
    end
  end

  // Flatten taps into the packed output, tap 0 in the low bits.
  always_comb begin
    bus.taps = '0;
    for (int k = 0; k < DEPTH; k++) bus.taps[k*DATA_W +: DATA_W] = taps_q[k];
  end

  assign bus.tap_out = tap_out_q;
  assign bus.fill    = fill_q;
  assign bus.full    = full_q;
  assign bus.win_sum = win_sum_q;
endmodule

// File: tb/tb_delay_line_param.sv
// Directed bench for delay_line_param: a DEPTH=4 and a DEPTH=5 instance,
// one task per scenario with inline comparisons against hand-computed values.
module tb_delay_line_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  delay_line_param_if #(.DATA_W(8), .DEPTH(4)) if4 ();
  delay_line_param_if #(.DATA_W(8), .DEPTH(5)) if5 ();

  delay_line_param #(.DATA_W(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  delay_line_param #(.DATA_W(8), .DEPTH(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

  // Clock
  always #5 clk = ~clk;

  // Advance one edge, then settle before sampling outputs.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.sample_en = 1'b1; if4.sample_in = 8'hAA; if4.flush = 1'b0; if4.tap_sel = 2'd0;
    if5.sample_en = 1'b1; if5.sample_in = 8'hAA; if5.flush = 1'b0; if5.tap_sel = 3'd0;
    cycle();
    cycle();
    n_checks++; if (if4.taps !== 32'h0) begin n_fail++; $display("FAIL reset_taps: got %h expected 0", if4.taps); end
    n_checks++; if (if4.tap_out !== 8'd0) begin n_fail++; $display("FAIL reset_tap_out: got %0d expected 0", if4.tap_out); end
    n_checks++; if (if4.fill !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", if4.fill); end
    n_checks++; if (if4.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0d expected 0", if4.full); end
    n_checks++; if (if4.win_sum !== 10'd0) begin n_fail++; $display("FAIL reset_win_sum: got %0d expected 0", if4.win_sum); end
    n_checks++; if (if5.taps !== 40'h0) begin n_fail++; $display("FAIL reset_taps5: got %h expected 0", if5.taps); end
    rst = 1'b0;
    if4.sample_en = 1'b0;
    if5.sample_en = 1'b0;
  endtask

  task automatic test_fill();
    int vals [4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      if4.sample_en = 1'b1;
      if4.sample_in = 8'(vals[i]);
      cycle();
      n_checks++; if (if4.fill !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, if4.fill, i + 1); end
      n_checks++; if (if4.full !== (i == 3)) begin n_fail++; $display("FAIL fill_full[%0d]: got %0d expected %0d", i, if4.full, (i == 3)); end
    end
    n_checks++; if (if4.taps !== {8'd10, 8'd20, 8'd30, 8'd40}) begin n_fail++; $display("FAIL fill_taps: got %h expected %h", if4.taps, {8'd10, 8'd20, 8'd30, 8'd40}); end
    n_checks++; if (if4.win_sum !== 10'd100) begin n_fail++; $display("FAIL fill_win_sum: got %0d expected 100", if4.win_sum); end
  endtask

  task automatic test_hold();
    if4.sample_en = 1'b1;
    if4.sample_in = 8'd50;
    cycle();
    n_checks++; if (if4.win_sum !== 10'd140) begin n_fail++; $display("FAIL shift_win_sum: got %0d expected 140", if4.win_sum); end
    if4.sample_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if4.sample_in = (i % 2 == 0) ? 8'hFF : 8'h5A;
      cycle();
      n_checks++; if (if4.taps !== {8'd20, 8'd30, 8'd40, 8'd50}) begin n_fail++; $display("FAIL hold_taps[%0d]: got %h expected %h", i, if4.taps, {8'd20, 8'd30, 8'd40, 8'd50}); end
      n_checks++; if (if4.win_sum !== 10'd140) begin n_fail++; $display("FAIL hold_win_sum[%0d]: got %0d expected 140", i, if4.win_sum); end
      n_checks++; if (if4.fill !== 3'd4) begin n_fail++; $display("FAIL hold_fill[%0d]: got %0d expected 4", i, if4.fill); end
    end
  endtask

  task automatic test_saturate();
    if4.sample_en = 1'b1;
    if4.sample_in = 8'd255;
    for (int i = 0; i < 4; i++) cycle();
    n_checks++; if (if4.win_sum !== 10'd1020) begin n_fail++; $display("FAIL sat_win_sum: got %0d expected 1020", if4.win_sum); end
    n_checks++; if (if4.taps !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_taps: got %h expected ffffffff", if4.taps); end
    n_checks++; if (if4.fill !== 3'd4 || if4.full !== 1'b1) begin n_fail++; $display("FAIL sat_fill_full: got %0d/%0d expected 4/1", if4.fill, if4.full); end
    if4.sample_in = 8'd0;
    cycle();
    n_checks++; if (if4.win_sum !== 10'd765) begin n_fail++; $display("FAIL drop_win_sum: got %0d expected 765", if4.win_sum); end
    n_checks++; if (if4.taps !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL drop_taps: got %h expected ffffff00", if4.taps); end
    if4.sample_en = 1'b0;
  endtask

  task automatic test_flush();
    // Taps are now tap0=0, tap1..3=255; tap 2 must be captured pre-flush.
    if4.flush = 1'b1;
    if4.sample_en = 1'b1;
    if4.sample_in = 8'd77;
    if4.tap_sel = 2'd2;
    cycle();
    n_checks++; if (if4.taps !== 32'h0) begin n_fail++; $display("FAIL flush_taps: got %h expected 0", if4.taps); end
    n_checks++; if (if4.fill !== 3'd0) begin n_fail++; $display("FAIL flush_fill: got %0d expected 0", if4.fill); end
    n_checks++; if (if4.full !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %0d expected 0", if4.full); end
    n_checks++; if (if4.win_sum !== 10'd0) begin n_fail++; $display("FAIL flush_win_sum: got %0d expected 0", if4.win_sum); end
    n_checks++; if (if4.tap_out !== 8'd255) begin n_fail++; $display("FAIL flush_tap_out: got %0d expected 255", if4.tap_out); end
    if4.flush = 1'b0;
    if4.sample_en = 1'b0;
    cycle();
    n_checks++; if (if4.taps !== 32'h0) begin n_fail++; $display("FAIL flush_no_load: got %h expected 0", if4.taps); end
    n_checks++; if (if4.tap_out !== 8'd0) begin n_fail++; $display("FAIL flush_tap_out_after: got %0d expected 0", if4.tap_out); end
  endtask

  task automatic test_read_port();
    int vals [5] = '{5, 4, 3, 2, 1};
    if5.sample_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if5.sample_in = 8'(vals[i]);
      cycle();
    end
    if5.sample_en = 1'b0;
    n_checks++; if (if5.taps !== {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}) begin n_fail++; $display("FAIL rd_taps: got %h expected %h", if5.taps, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}); end
    n_checks++; if (if5.win_sum !== 11'd15 || if5.full !== 1'b1 || if5.fill !== 3'd5) begin n_fail++; $display("FAIL rd_sum_fill: got %0d/%0d/%0d expected 15/5/1", if5.win_sum, if5.fill, if5.full); end
    if5.tap_sel = 3'd4;
    cycle();
    n_checks++; if (if5.tap_out !== 8'd5) begin n_fail++; $display("FAIL rd_sel4: got %0d expected 5", if5.tap_out); end
    if5.tap_sel = 3'd7;
    cycle();
    n_checks++; if (if5.tap_out !== 8'd0) begin n_fail++; $display("FAIL rd_sel7: got %0d expected 0", if5.tap_out); end
    if5.tap_sel = 3'd5;
    cycle();
    n_checks++; if (if5.tap_out !== 8'd0) begin n_fail++; $display("FAIL rd_sel5: got %0d expected 0", if5.tap_out); end
    // Read and shift on the same edge: tap_out sees the old tap 0.
    if5.tap_sel = 3'd0;
    if5.sample_en = 1'b1;
    if5.sample_in = 8'd9;
    cycle();
    if5.sample_en = 1'b0;
    n_checks++; if (if5.tap_out !== 8'd1) begin n_fail++; $display("FAIL rd_pre_shift: got %0d expected 1", if5.tap_out); end
    n_checks++; if (if5.win_sum !== 11'd19) begin n_fail++; $display("FAIL rd_shift_sum: got %0d expected 19", if5.win_sum); end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    if5.sample_en = 1'b1;
    if5.sample_in = 8'd33;
    cycle();
    n_checks++; if (if5.taps !== 40'h0 || if5.win_sum !== 11'd0 || if5.fill !== 3'd0 || if5.full !== 1'b0 || if5.tap_out !== 8'd0) begin n_fail++; $display("FAIL mid_reset: got taps %h sum %0d fill %0d full %0d out %0d expected all 0", if5.taps, if5.win_sum, if5.fill, if5.full, if5.tap_out); end
    rst = 1'b0;
    if5.sample_in = 8'd6;
    cycle();
    if5.sample_en = 1'b0;
    n_checks++; if (if5.fill !== 3'd1) begin n_fail++; $display("FAIL mid_fill: got %0d expected 1", if5.fill); end
    n_checks++; if (if5.taps !== 40'h06) begin n_fail++; $display("FAIL mid_taps: got %h expected 06", if5.taps); end
    n_checks++; if (if5.win_sum !== 11'd6) begin n_fail++; $display("FAIL mid_sum: got %0d expected 6", if5.win_sum); end
  endtask

  // Scenario sequence and final report
  initial begin
    if4.sample_en = 1'b0; if4.flush = 1'b0; if4.sample_in = '0; if4.tap_sel = '0;
    if5.sample_en = 1'b0; if5.flush = 1'b0; if5.sample_in = '0; if5.tap_sel = '0;
    test_reset();
    test_fill();
    test_hold();
    test_saturate();
    test_flush();
    test_read_port();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_line_param.md
Name: delay_line_param

Overview:
- Parameterised successor of the 4-tap 8-bit sample delay line.
- Shifts a DATA_W-bit sample stream through DEPTH taps on qualified strobes only, so taps hold during register-write cycles.
- Adds a synchronous flush, a fill counter with a full flag, a registered tap-select read port and an incrementally maintained window sum.
- Sits between the sample source and the FIR/averaging datapath.

Parameters:
- DATA_W, 8, sample width in bits, unsigned; must be >= 1.
- DEPTH, 4, number of taps; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- sample_en  in  1  shift/accept strobe, one sample per high cycle.
- flush  in  1  synchronous clear of the tap contents.
- sample_in  in  DATA_W  incoming sample.
- tap_sel  in  SEL_W  tap index for the read port.
- taps  out  DATA_W*DEPTH  packed taps; tap k = bits [k*DATA_W +: DATA_W]; tap 0 is newest.
- tap_out  out  DATA_W  registered selected tap.
- fill  out  CNT_W  number of samples accepted since reset/flush, saturating at DEPTH.
- full  out  1  high when fill == DEPTH.
- win_sum  out  SUM_W  sum of all DEPTH taps.

Behaviour:
- Derived widths:
  - SEL_W = max(1, clog2(DEPTH)).
  - CNT_W = clog2(DEPTH+1).
  - SUM_W = DATA_W + clog2(DEPTH).
  - win_sum can never overflow.
- Reset: while rst is high at a rising edge, these outputs go to 0 on that edge: all taps, tap_out, fill, full, win_sum. rst overrides flush and sample_en. Reset mid-stream discards all history; the first accepted sample after release is newest at fill = 1.
- Priority at each edge: rst > flush > sample_en > hold.
- Flush (rst low, flush high):
  - Taps, fill and win_sum go to 0 and full deasserts.
  - A simultaneous sample_en is dropped; the sample is not loaded.
  - tap_out still updates per the read-port rule below, so it captures the pre-flush tap.
- Shift (rst low, flush low, sample_en high):
  - tap k <= tap k-1 for k = 1..DEPTH-1.
  - tap 0 <= sample_in.
  - The old tap DEPTH-1 is discarded.
  - win_sum <= win_sum + sample_in - old tap[DEPTH-1], computed at SUM_W bits. Unfilled taps are 0, so no fill-dependent special case is needed.
  - fill <= min(fill+1, DEPTH).
  - full <= (fill+1 >= DEPTH).
- Hold (sample_en low, no flush): taps, fill, full and win_sum keep their values. This is required when sample_en drops for register-write cycles.
- Update latency:
  - taps, fill, full and win_sum reflect an accepted sample on the edge that accepts it (1-cycle latency from sample_in).
  - The four are always mutually consistent: win_sum == the sum of the taps visible in the same cycle.
- Read port:
  - Every non-reset edge, tap_out <= tap[tap_sel], using tap values from before that edge's shift.
  - tap_sel >= DEPTH gives tap_out <= 0.
  - Net latency is 1 cycle from tap_sel to tap_out.
- Width rules:
  - All arithmetic is unsigned.
  - sample_in is zero-extended to SUM_W before the add.
  - The subtract cannot underflow, because old tap[DEPTH-1] is always included in win_sum.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- rst=1 for 2 cycles with sample_en=1 and sample_in=0xAA -> all taps, tap_out, fill, full and win_sum are 0.
- DATA_W=8, DEPTH=4: accept 10,20,30,40 on consecutive cycles. After each edge, fill reads 1,2,3,4 and full rises with the 4th sample. Final state: taps = {40,30,20,10} (tap0..3), win_sum = 100.
- Continue with sample 50, then drop sample_en for 3 cycles with sample_in toggling -> taps = {50,40,30,20} and win_sum = 140 are held, fill = 4.
- Accept 255 four times -> win_sum = 1020 (10-bit, no wrap). Then accept 0 -> win_sum = 765.
- With the taps filled, assert flush together with sample_en and sample_in = 77 -> taps are 0, fill = 0, win_sum = 0, and 77 is not loaded. On the same cycle, tap_sel = 2 captures the pre-flush tap 2 into tap_out.
- Read port with DEPTH=5 and taps {1,2,3,4,5}: tap_sel=4 -> tap_out = 5 next cycle; tap_sel=7 -> tap_out = 0. Then assert rst mid-stream -> everything clears, and the next accepted sample gives fill = 1.
